// File: rtl/hgcal_input_packer.sv
// rtl/hgcal_input_packer.sv - quantises signed samples to 2-bit codes and packs FANIN codes per output word
//
// Optional feature macro: PACKER_SAT_COUNT_EN (clamped-sample counter on sat_count)
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   s_valid/s_ready     input sample handshake
//   s_data, s_last      two's-complement sample, end-of-event marker
//   m_valid/m_ready     packed word handshake
//   m_data, m_last      packed codes (first code in the top pair), end-of-event word
//   sat_count, sat_clr  clamped-sample counter and its synchronous clear
module hgcal_input_packer #(
    parameter int IN_W  = 16,
    parameter int SHIFT = 4,
    parameter int FANIN = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [IN_W-1:0]      s_data,
    input  logic                 s_last,
    output logic                 m_valid,
    input  logic                 m_ready,
    output logic [2*FANIN-1:0]   m_data,
    output logic                 m_last,
    output logic [15:0]          sat_count,
    input  logic                 sat_clr
);

    localparam int SW = (FANIN > 1) ? $clog2(FANIN) : 1;
    localparam logic [SW-1:0] LAST_SLOT = SW'(FANIN - 1);

    logic [2*FANIN-1:0] r_coll;
    logic [SW-1:0]      r_slot;
    logic [2*FANIN-1:0] r_m_data;
    logic               r_m_valid;
    logic               r_m_last;
    logic               r_run;

    logic               w_neg;
    logic [IN_W-1:0]    w_step;
    logic [1:0]         w_code;
    logic               w_complete;
    logic               w_acc;
    logic [2*FANIN-1:0] w_word;

    assign w_neg  = s_data[IN_W-1];
    // Only consulted for non-negative samples, so a logical shift is enough.
    assign w_step = s_data >> SHIFT;

    always_comb begin
        w_code = 2'b00;
        if (w_neg)
            w_code = 2'b00;
        else if (w_step >= IN_W'(3))
            w_code = 2'b11;
        else
            w_code = s_data[SHIFT+1:SHIFT];
    end

    // A flushed word needs no explicit zero fill: r_coll is cleared after every word.
    always_comb begin
        w_word = r_coll;
        for (int i = 0; i < FANIN; i++) begin
            if (SW'(i) == r_slot)
                w_word[2*FANIN-1-2*i -: 2] = w_code;
        end
    end

    assign w_complete = (r_slot == LAST_SLOT) | s_last;
    // Only the completing sample needs a free output register; partial slots keep filling.
    assign s_ready    = r_run & ~(w_complete & r_m_valid & ~m_ready);
    assign w_acc      = s_valid & s_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run     <= 1'b0;
            r_coll    <= '0;
            r_slot    <= '0;
            r_m_data  <= '0;
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end else begin
            r_run <= 1'b1;
            if (w_acc && w_complete) begin
                r_coll    <= '0;
                r_slot    <= '0;
                r_m_data  <= w_word;
                r_m_valid <= 1'b1;
                r_m_last  <= s_last;
            end else begin
                if (w_acc) begin
                    r_coll <= w_word;
                    r_slot <= r_slot + SW'(1);
                end
                if (m_ready)
                    r_m_valid <= 1'b0;
            end
        end
    end

    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;

`ifdef PACKER_SAT_COUNT_EN
    logic        w_clamp;
    logic [15:0] r_sat;

    assign w_clamp = w_neg | (s_data >= IN_W'(4 << SHIFT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sat <= '0;
        else if (sat_clr)
            r_sat <= '0;
        else if (w_acc && w_clamp && (r_sat != 16'hFFFF))
            r_sat <= r_sat + 16'd1;
    end

    assign sat_count = r_sat;
`else
    logic w_sat_clr_unused;
    assign w_sat_clr_unused = sat_clr;
    assign sat_count        = 16'd0;
`endif

endmodule
